// File: rtl/mcctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control unit: FSM states,
// opcodes, ALU operation classes and datapath select codes.
package mcctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Immediate format depends only on the opcode, independent of FSM state.
    function automatic logic [1:0] immSrcOf(input logic [6:0] op);
        logic [1:0] imm;
        imm = IMM_I;
        case (op)
            OP_SW:   imm = IMM_S;
            OP_BEQ:  imm = IMM_B;
            OP_JAL:  imm = IMM_J;
            default: imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALUOp class plus the
// instruction's funct fields to a concrete ALUControl code.
module alu_decoder
    import mcctrl_pkg::*;
(
    input  aluop_t      ALUOp,
    input  logic        op5,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    output logic [2:0]  ALUControl
);

    // Only R-type (op[5]=1) with bit 30 set subtracts; addi never does.
    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM control unit for the multi-cycle RISC-V datapath.
// Optional performance counters are enabled with the MCCTRL_PERF_EN macro.
module multicycle_controller
    import mcctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               Zero,
    input  logic               stall,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [2:0]         ALUControl,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic               RegWrite,
    output logic               illegal_op,
`ifdef MCCTRL_PERF_EN
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        instret_cnt,
`endif
    output logic [STATE_W-1:0] fsm_state
);

    state_t r_state;
    state_t w_next;
    aluop_t w_aluOp;
    logic   r_illegal;
    logic   w_pcWrite;
    logic   w_irWrite;
    logic   w_memWrite;
    logic   w_regWrite;
    logic   w_writeOk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // A stalled cycle simply re-evaluates the same state next cycle.
    always_comb begin
        w_next = r_state;
        if (!stall) begin
            case (r_state)
                S_FETCH:  w_next = S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: w_next = S_MEMADR;
                        OP_R:         w_next = S_EXECR;
                        OP_I:         w_next = S_EXECI;
                        OP_BEQ:       w_next = S_BEQ;
                        OP_JAL:       w_next = S_JAL;
                        default:      w_next = S_TRAP;
                    endcase
                end
                S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  w_next = S_MEMWB;
                S_MEMWB:    w_next = S_FETCH;
                S_MEMWRITE: w_next = S_FETCH;
                S_EXECR:    w_next = S_ALUWB;
                S_EXECI:    w_next = S_ALUWB;
                S_ALUWB:    w_next = S_FETCH;
                S_BEQ:      w_next = S_FETCH;
                S_JAL:      w_next = S_ALUWB;
                S_TRAP:     w_next = S_TRAP;
                default:    w_next = S_TRAP;
            endcase
        end
    end

    always_comb begin
        w_pcWrite  = 1'b0;
        w_irWrite  = 1'b0;
        w_memWrite = 1'b0;
        w_regWrite = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_WD;
        w_aluOp    = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_irWrite = 1'b1;
                w_pcWrite = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                w_regWrite = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_WD;
                w_aluOp = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                w_aluOp = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_regWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA   = SRCA_A;
                ALUSrcB   = SRCB_WD;
                w_aluOp   = ALUOP_SUB;
                w_pcWrite = Zero;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                w_pcWrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Reset and stall both veto every architectural write, even in FETCH.
    assign w_writeOk = ~reset & ~stall;
    assign PCWrite   = w_pcWrite  & w_writeOk;
    assign IRWrite   = w_irWrite  & w_writeOk;
    assign MemWrite  = w_memWrite & w_writeOk;
    assign RegWrite  = w_regWrite & w_writeOk;

    assign ImmSrc    = immSrcOf(op);
    assign fsm_state = STATE_W'(r_state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else if (w_next == S_TRAP) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal_op = r_illegal;

    alu_decoder u_aluDecoder (
        .ALUOp      (w_aluOp),
        .op5        (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .ALUControl (ALUControl)
    );

`ifdef MCCTRL_PERF_EN
    logic [31:0] r_cycleCnt;
    logic [31:0] r_instretCnt;
    logic        w_retire;

    // An instruction retires when a terminal state hands control back to FETCH.
    assign w_retire = !stall && (w_next == S_FETCH) &&
                      ((r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                       (r_state == S_ALUWB) || (r_state == S_BEQ));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycleCnt   <= 32'd0;
            r_instretCnt <= 32'd0;
        end else begin
            r_cycleCnt <= r_cycleCnt + 32'd1;
            if (w_retire) begin
                r_instretCnt <= r_instretCnt + 32'd1;
            end
        end
    end

    assign cycle_cnt   = r_cycleCnt;
    assign instret_cnt = r_instretCnt;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller, with hand sequences for
// the trap/reset corner and (under MCCTRL_PERF_EN) the perf counters.
module tb_multicycle_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       stall;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] fsm_state;
`ifdef MCCTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int nVec = 0;
    int nMis = 0;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .stall      (stall),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .illegal_op (illegal_op),
`ifdef MCCTRL_PERF_EN
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt),
`endif
        .fsm_state  (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output bits: PCWrite AdrSrc MemWrite IRWrite ResultSrc
    // ALUControl ALUSrcA ALUSrcB ImmSrc RegWrite illegal_op.
    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic        st;
        logic [3:0]  state;
        logic [16:0] outs;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                input logic z, input logic st, input logic [3:0] s,
                                input logic [16:0] outs);
        vec_t v;
        v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.st = st; v.state = s; v.outs = outs;
        return v;
    endfunction

    function automatic logic [16:0] actualOuts();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
                ALUSrcA, ALUSrcB, ImmSrc, RegWrite, illegal_op};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one vector, check the Moore outputs of the current state, then clock.
    task automatic applyStimulus(input vec_t v, input int idx);
        op = v.op; funct3 = v.f3; funct7b5 = v.f7; Zero = v.z; stall = v.st;
        #1;
        checkOutput($sformatf("vec%0d", idx), {11'b0, fsm_state, actualOuts()},
                    {11'b0, v.state, v.outs});
        @(posedge clk);
        #1;
    endtask

    // FETCH and DECODE rows for an instruction whose ImmSrc is imm.
    task automatic addFetchDecode(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                  input logic [1:0] imm);
        vecs.push_back(mk(o, f3, f7, 0, 0, 4'd0, {4'b1001, 2'b10, 3'b000, 2'b00, 2'b10, imm, 2'b00}));
        vecs.push_back(mk(o, f3, f7, 0, 0, 4'd1, {4'b0000, 2'b00, 3'b000, 2'b01, 2'b01, imm, 2'b00}));
    endtask

    initial begin
        reset = 1'b1; op = LW; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0; stall = 1'b0;

        // lw: 0,1,2,3,4
        addFetchDecode(LW, 3'b010, 0, 2'b00);
        vecs.push_back(mk(LW, 3'b010, 0, 0, 0, 4'd2, 17'b0_0_0_0_00_000_10_01_00_0_0));
        vecs.push_back(mk(LW, 3'b010, 0, 0, 0, 4'd3, 17'b0_1_0_0_00_000_00_00_00_0_0));
        vecs.push_back(mk(LW, 3'b010, 0, 0, 0, 4'd4, 17'b0_0_0_0_01_000_00_00_00_1_0));
        // sw with a stalled FETCH, then 3 stalled MEMWRITE cycles
        vecs.push_back(mk(SW, 3'b010, 0, 0, 1, 4'd0, 17'b0_0_0_0_10_000_00_10_01_0_0));
        addFetchDecode(SW, 3'b010, 0, 2'b01);
        vecs.push_back(mk(SW, 3'b010, 0, 0, 0, 4'd2, 17'b0_0_0_0_00_000_10_01_01_0_0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(SW, 3'b010, 0, 0, 1, 4'd5, 17'b0_1_0_0_00_000_00_00_01_0_0));
        vecs.push_back(mk(SW, 3'b010, 0, 0, 0, 4'd5, 17'b0_1_1_0_00_000_00_00_01_0_0));
        // R-type sub, with one stalled ALUWB
        addFetchDecode(RT, 3'b000, 1, 2'b00);
        vecs.push_back(mk(RT, 3'b000, 1, 0, 0, 4'd6, 17'b0_0_0_0_00_001_10_00_00_0_0));
        vecs.push_back(mk(RT, 3'b000, 1, 0, 1, 4'd8, 17'b0_0_0_0_00_000_00_00_00_0_0));
        vecs.push_back(mk(RT, 3'b000, 1, 0, 0, 4'd8, 17'b0_0_0_0_00_000_00_00_00_1_0));
        // R-type add, slt, or
        addFetchDecode(RT, 3'b000, 0, 2'b00);
        vecs.push_back(mk(RT, 3'b000, 0, 0, 0, 4'd6, 17'b0_0_0_0_00_000_10_00_00_0_0));
        vecs.push_back(mk(RT, 3'b000, 0, 0, 0, 4'd8, 17'b0_0_0_0_00_000_00_00_00_1_0));
        addFetchDecode(RT, 3'b010, 0, 2'b00);
        vecs.push_back(mk(RT, 3'b010, 0, 0, 0, 4'd6, 17'b0_0_0_0_00_101_10_00_00_0_0));
        vecs.push_back(mk(RT, 3'b010, 0, 0, 0, 4'd8, 17'b0_0_0_0_00_000_00_00_00_1_0));
        addFetchDecode(RT, 3'b110, 0, 2'b00);
        vecs.push_back(mk(RT, 3'b110, 0, 0, 0, 4'd6, 17'b0_0_0_0_00_011_10_00_00_0_0));
        vecs.push_back(mk(RT, 3'b110, 0, 0, 0, 4'd8, 17'b0_0_0_0_00_000_00_00_00_1_0));
        // addi with bit 30 set still adds; andi
        addFetchDecode(IT, 3'b000, 1, 2'b00);
        vecs.push_back(mk(IT, 3'b000, 1, 0, 0, 4'd7, 17'b0_0_0_0_00_000_10_01_00_0_0));
        vecs.push_back(mk(IT, 3'b000, 1, 0, 0, 4'd8, 17'b0_0_0_0_00_000_00_00_00_1_0));
        addFetchDecode(IT, 3'b111, 0, 2'b00);
        vecs.push_back(mk(IT, 3'b111, 0, 0, 0, 4'd7, 17'b0_0_0_0_00_010_10_01_00_0_0));
        vecs.push_back(mk(IT, 3'b111, 0, 0, 0, 4'd8, 17'b0_0_0_0_00_000_00_00_00_1_0));
        // beq taken (one stalled cycle first), then not taken
        addFetchDecode(BQ, 3'b000, 0, 2'b10);
        vecs.push_back(mk(BQ, 3'b000, 0, 1, 1, 4'd9, 17'b0_0_0_0_00_001_10_00_10_0_0));
        vecs.push_back(mk(BQ, 3'b000, 0, 1, 0, 4'd9, 17'b1_0_0_0_00_001_10_00_10_0_0));
        addFetchDecode(BQ, 3'b000, 0, 2'b10);
        vecs.push_back(mk(BQ, 3'b000, 0, 0, 0, 4'd9, 17'b0_0_0_0_00_001_10_00_10_0_0));
        // jal
        addFetchDecode(JL, 3'b000, 0, 2'b11);
        vecs.push_back(mk(JL, 3'b000, 0, 0, 0, 4'd10, 17'b1_0_0_0_00_000_01_10_11_0_0));
        vecs.push_back(mk(JL, 3'b000, 0, 0, 0, 4'd8, 17'b0_0_0_0_00_000_00_00_11_1_0));
        // illegal opcode into TRAP
        addFetchDecode(BAD, 3'b000, 0, 2'b00);
        vecs.push_back(mk(BAD, 3'b000, 0, 0, 0, 4'd11, 17'b0_0_0_0_00_000_00_00_00_0_1));

        // Reset state, with FETCH's enables vetoed by reset
        @(negedge clk);
        #1;
        checkOutput("reset", {11'b0, fsm_state, actualOuts()},
                    {11'b0, 4'd0, 17'b0_0_0_0_10_000_00_10_00_0_0});
        reset = 1'b0;

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // TRAP must absorb for 20 cycles with all enables low
        Zero = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checkOutput($sformatf("trap%0d", i),
                        {fsm_state, PCWrite, IRWrite, MemWrite, RegWrite, illegal_op},
                        {4'd11, 4'b0000, 1'b1});
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-trap
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("trapReset", {fsm_state, illegal_op, PCWrite, IRWrite},
                    {4'd0, 1'b0, 1'b0, 1'b0});

`ifdef MCCTRL_PERF_EN
        @(negedge clk);
        reset = 1'b0; stall = 1'b0; Zero = 1'b0; op = LW; funct3 = 3'b010; funct7b5 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("perfLwDone", {28'b0, fsm_state}, 32'd0);
        op = JL;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("perfState", {28'b0, fsm_state}, 32'd0);
        checkOutput("cycleCnt", cycle_cnt, 32'd9);
        checkOutput("instretCnt", instret_cnt, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
